// File: rtl/cart_rom_fetch.sv
// Cartridge ROM fetch stage: serves mapper byte reads from one 8-byte line
// buffer and refills it with a 4-word burst over a req/ack SDRAM port on a miss.
module cart_rom_fetch (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [22:0] mbc_addr,
  input  logic        inval,
  output logic        busy,
  output logic [7:0]  rom_do,
  output logic        rom_valid,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;

  logic [1:0]  r_state;
  logic [19:0] r_tag;
  logic        r_line_valid;
  logic [15:0] r_line [4];
  logic [22:0] r_addr;
  logic [1:0]  r_cnt;
  logic        r_stale;
  logic [7:0]  r_rom_hold;

  logic        w_hit;
  logic [15:0] w_word;
  logic [7:0]  w_byte;

  // An invalidate in the same cycle as a request forces that request to miss.
  assign w_hit  = r_line_valid && (r_tag == mbc_addr[22:3]) && !inval;
  assign w_word = r_line[r_addr[2:1]];
  assign w_byte = r_addr[0] ? w_word[15:8] : w_word[7:0];

  assign busy       = (r_state != S_IDLE);
  assign rom_valid  = (r_state == S_RETURN);
  assign rom_do     = rom_valid ? w_byte : r_rom_hold;
  assign sdram_req  = (r_state == S_FILL);
  assign sdram_addr = sdram_req ? {r_addr[22:3], r_cnt} : 22'd0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_stale      <= 1'b0;
      r_rom_hold   <= 8'hFF;
      for (int i = 0; i < 4; i++) r_line[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inval) r_line_valid <= 1'b0;
          if (rd_req) begin
            r_addr <= mbc_addr;
            if (w_hit) begin
              r_state <= S_RETURN;
            end else begin
              r_state      <= S_FILL;
              r_cnt        <= 2'd0;
              r_stale      <= 1'b0;
              r_line_valid <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (inval) begin
            r_line_valid <= 1'b0;
            r_stale      <= 1'b1;
          end
          if (sdram_ack) begin
            r_line[r_cnt] <= sdram_data;
            r_cnt         <= r_cnt + 2'd1;
            // Last word: the line only becomes resident if no invalidate hit it.
            if (r_cnt == 2'd3) begin
              r_tag        <= r_addr[22:3];
              r_line_valid <= ~(r_stale | inval);
              r_state      <= S_RETURN;
            end
          end
        end
        S_RETURN: begin
          if (inval) r_line_valid <= 1'b0;
          r_rom_hold <= w_byte;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
